// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : aes_pkg
//  Description : Shared AES-128 types, constants and GF(2^8) helpers for the
//                inverse cipher: state type, S-box / inverse S-box, round
//                constants, xtime, InvMixColumns on one column and the word
//                helpers used by the key schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Number of rounds; only AES-128 is supported.
    localparam int NR = 10;

    // 16 bytes; element [15] is byte 0 (bits [127:120]), column-major.
    typedef logic [15:0][7:0] state_t;

    // Round constants indexed by round number 1..10; other slots are unused.
    localparam logic [7:0] c_rcon [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h01;
        s = a;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            p = gf_mul(p, s);
        end
        return p;
    endfunction

    // S-box: field inverse followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // InvMixColumns on one column; byte a0 sits in the top bits.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] o0, o1, o2, o3;
        {a0, a1, a2, a3} = c;
        o0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        o1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        o2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        o3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        return {o0, o1, o2, o3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_if.sv
`default_nettype none
// ============================================================================
//  Interface   : aes_inv_cipher_if
//  Description : Key-load and block handshake bundle of the AES-128 inverse
//                cipher.
//                kld/key      : key-load strobe and cipher key
//                kdone        : last round key ready (level)
//                ld/text_in   : block-load strobe and ciphertext
//                done/text_out: one-cycle result strobe and plaintext
//                master drives strobes/data in; slave is the cipher.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_inv_cipher_if;
    import aes_pkg::*;

    logic         kld;
    logic [127:0] key;
    logic         kdone;
    logic         ld;
    logic [127:0] text_in;
    logic         done;
    logic [127:0] text_out;

    modport master (
        output kld, key, ld, text_in,
        input  kdone, done, text_out
    );

    modport slave (
        input  kld, key, ld, text_in,
        output kdone, done, text_out
    );

endinterface
`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_key_sched
//  Description : AES-128 key schedule for the inverse cipher. A kld strobe
//                captures the key and runs ten forward expansion steps, one
//                per clock, storing the last round key in rk10 and raising
//                kdone. During a decryption a working key register walks the
//                schedule backwards one round per clock.
//  Ports       : clk, rst (sync, active low)
//                i_kld, i_key        : start expansion from a new key
//                i_wk_load           : working key <= rk10
//                i_wk_step           : working key <= previous round key
//                i_round             : round index of the current working key
//                o_kdone             : rk10 valid
//                o_rk10              : last round key
//                o_prev_key          : round key (i_round - 1), combinational
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_sched (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_kld,
    input  wire logic [127:0] i_key,
    input  wire logic         i_wk_load,
    input  wire logic         i_wk_step,
    input  wire logic [3:0]   i_round,
    output logic              o_kdone,
    output logic [127:0]      o_rk10,
    output logic [127:0]      o_prev_key
);
    import aes_pkg::*;

    localparam logic [3:0] c_last = 4'(NR);

    logic [127:0] r_exp_key;
    logic [3:0]   r_exp_round;
    logic         r_exp_busy;
    logic [127:0] r_rk10;
    logic [127:0] r_wk;
    logic         r_kdone;
    logic [127:0] w_next_key;
    logic [127:0] w_prev_key;

    // rk(r) from rk(r-1).
    function automatic logic [127:0] expand_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // rk(r-1) from rk(r): the top three words undo the chained XOR first,
    // then the recovered last word feeds RotWord/SubWord for word 0.
    function automatic logic [127:0] expand_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    assign w_next_key = expand_fwd(r_exp_key, c_rcon[r_exp_round]);
    assign w_prev_key = expand_inv(r_wk, c_rcon[i_round]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exp_key   <= '0;
            r_exp_round <= '0;
            r_exp_busy  <= 1'b0;
            r_rk10      <= '0;
            r_wk        <= '0;
            r_kdone     <= 1'b0;
        end else begin
            if (i_kld) begin
                // A new key always restarts expansion, even mid-expansion.
                r_exp_key   <= i_key;
                r_exp_round <= 4'd1;
                r_exp_busy  <= 1'b1;
                r_kdone     <= 1'b0;
            end else if (r_exp_busy) begin
                r_exp_key <= w_next_key;
                if (r_exp_round == c_last) begin
                    r_rk10      <= w_next_key;
                    r_kdone     <= 1'b1;
                    r_exp_busy  <= 1'b0;
                    r_exp_round <= '0;
                end else begin
                    r_exp_round <= r_exp_round + 4'd1;
                end
            end

            if (i_wk_load) begin
                r_wk <= r_rk10;
            end else if (i_wk_step) begin
                r_wk <= w_prev_key;
            end
        end
    end

    assign o_kdone    = r_kdone;
    assign o_rk10     = r_rk10;
    assign o_prev_key = w_prev_key;

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_top.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_cipher_top
//  Description : Iterative AES-128 inverse cipher, one round per clock.
//                An accepted ld XORs the ciphertext with rk10; the next nine
//                clocks run full inverse rounds and the tenth runs the final
//                round, loads text_out and pulses done.
//  Ports       : clk  - clock
//                rst  - synchronous reset, active low
//                bus  - aes_inv_cipher_if.slave (kld/key/kdone,
//                       ld/text_in, done/text_out)
//  Parameters  : NR   - number of rounds; only 10 (AES-128) is supported
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_top #(
    parameter int NR = 10
) (
    input  wire logic       clk,
    input  wire logic       rst,
    aes_inv_cipher_if.slave bus
);
    import aes_pkg::*;

    localparam logic [3:0] c_nr = 4'(NR);

    state_t       r_state;
    logic [127:0] r_text_out;
    logic         r_busy;
    logic         r_done;
    logic [3:0]   r_round;

    logic         w_kdone;
    logic [127:0] w_rk10;
    logic [127:0] w_prev_key;
    logic         w_accept;
    state_t       w_sub;
    state_t       w_ark;
    state_t       w_imc;

    // kld wins over ld on the same edge.
    assign w_accept = bus.ld & w_kdone & ~r_busy & ~bus.kld;

    aes_inv_key_sched u_key_sched (
        .clk        (clk),
        .rst        (rst),
        .i_kld      (bus.kld),
        .i_key      (bus.key),
        .i_wk_load  (w_accept),
        .i_wk_step  (r_busy & ~bus.kld),
        .i_round    (r_round),
        .o_kdone    (w_kdone),
        .o_rk10     (w_rk10),
        .o_prev_key (w_prev_key)
    );

    // InvShiftRows + InvSubBytes: output byte (row r, col c) takes input
    // byte (row r, col c-r mod 4); byte b lives in element [15-b].
    for (genvar b = 0; b < 16; b++) begin : g_byte
        localparam int c_src = 4 * (((b / 4) + 4 - (b % 4)) % 4) + (b % 4);
        assign w_sub[15-b] = inv_sbox(r_state[15-c_src]);
    end

    assign w_ark = w_sub ^ w_prev_key;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_imc[15-4*c -: 4] = inv_mix_col(w_ark[15-4*c -: 4]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= '0;
            r_text_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_round    <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.kld) begin
                // Abort any block in flight; text_out keeps its last result.
                r_busy  <= 1'b0;
                r_round <= '0;
            end else if (w_accept) begin
                r_state <= bus.text_in ^ w_rk10;
                r_busy  <= 1'b1;
                r_round <= c_nr;
            end else if (r_busy) begin
                if (r_round == 4'd1) begin
                    // Final round: no InvMixColumns.
                    r_text_out <= w_ark;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_round    <= '0;
                end else begin
                    r_state <= w_imc;
                    r_round <= r_round - 4'd1;
                end
            end
        end
    end

    assign bus.kdone    = w_kdone;
    assign bus.done     = r_done;
    assign bus.text_out = r_text_out;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_cipher_top
//  Description : Self-checking bench for aes_inv_cipher_top. Known-answer
//                vectors from a table, plus back-to-back, ignored-ld, abort
//                and reset sequences. Expected plaintext and done cycle are
//                queued when ld is driven and checked when done appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_top;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   last_done_cyc = 0;

    typedef struct {
        logic [127:0] pt;
        int           cyc;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        bit           chk_rk;
        logic [127:0] rk10;
    } vec_t;
    vec_t vecs [3];

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_inv_cipher_if bus ();

    aes_inv_cipher_top #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Done monitor / scoreboard checker.
    initial begin : mon
        sb_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                n_done = n_done + 1;
                last_done_cyc = cyc;
                n_cmp = n_cmp + 1;
                if (sb.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_done: got done=1 text_out=%h at cycle %0d, required no done",
                             bus.text_out, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.text_out !== e.pt || cyc != e.cyc) begin
                        n_fail = n_fail + 1;
                        $display("FAIL done_result: got text_out=%h at cycle %0d, required %h at cycle %0d",
                                 bus.text_out, cyc, e.pt, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, output int k0);
        bus.key = k;
        bus.kld = 1'b1;
        tick(1);
        bus.kld = 1'b0;
        k0 = cyc;
    endtask

    task automatic start_ld(input logic [127:0] ct, input bit expect_ok, input logic [127:0] pt);
        sb_t it;
        bus.text_in = ct;
        bus.ld = 1'b1;
        tick(1);
        bus.ld = 1'b0;
        if (expect_ok) begin
            it.pt  = pt;
            it.cyc = cyc + 10;
            sb.push_back(it);
        end
    endtask

    task automatic wait_kdone(input int k0, input string name);
        int n;
        n = 0;
        while (bus.kdone !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        chk(name, 128'(cyc - k0), 128'd10);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        chk(name, 128'(sb.size()), 128'd0);
    endtask

    initial begin
        int k0;
        int snap;
        int t1;
        int n;

        vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT, chk_rk: 1'b1, rk10: C1_RK10};
        vecs[1] = '{key: B_KEY,  ct: B_CT,  pt: B_PT,  chk_rk: 1'b1, rk10: B_RK10};
        vecs[2] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    pt: 128'h0, chk_rk: 1'b0, rk10: 128'h0};

        bus.kld = 1'b0;
        bus.key = '0;
        bus.ld = 1'b0;
        bus.text_in = '0;

        // Reset state.
        rst = 1'b0;
        tick(3);
        chk("reset_kdone", 128'(bus.kdone), 128'd0);
        chk("reset_done", 128'(bus.done), 128'd0);
        chk("reset_text_out", bus.text_out, 128'd0);
        rst = 1'b1;
        tick(1);

        // ld before any key is loaded is ignored.
        snap = n_done;
        start_ld(C1_CT, 1'b0, '0);
        tick(15);
        chk("early_ld_no_done", 128'(n_done - snap), 128'd0);

        // Known-answer vectors.
        for (int i = 0; i < 3; i++) begin
            load_key(vecs[i].key, k0);
            chk($sformatf("v%0d_kdone_low", i), 128'(bus.kdone), 128'd0);
            wait_kdone(k0, $sformatf("v%0d_kdone_latency", i));
            if (vecs[i].chk_rk)
                chk($sformatf("v%0d_rk10", i), dut.u_key_sched.r_rk10, vecs[i].rk10);
            start_ld(vecs[i].ct, 1'b1, vecs[i].pt);
            drain($sformatf("v%0d_drain", i));
            tick(3);
            chk($sformatf("v%0d_text_out_held", i), bus.text_out, vecs[i].pt);
        end

        // Back-to-back: second ld on the done-high cycle.
        load_key(C1_KEY, k0);
        wait_kdone(k0, "b2b_kdone_latency");
        start_ld(C1_CT, 1'b1, C1_PT);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        t1 = cyc;
        start_ld(C1_CT, 1'b1, C1_PT);
        drain("b2b_drain");
        chk("b2b_spacing", 128'(last_done_cyc - t1), 128'd11);

        // ld while busy is ignored; original block completes.
        snap = n_done;
        start_ld(C1_CT, 1'b1, C1_PT);
        tick(2);
        start_ld(B_CT, 1'b0, '0);
        drain("midld_drain");
        tick(15);
        chk("midld_single_done", 128'(n_done - snap), 128'd1);

        // kld sampled at E5 aborts the block.
        snap = n_done;
        start_ld(C1_CT, 1'b0, '0);
        tick(4);
        load_key(B_KEY, k0);
        chk("abort_kdone_low", 128'(bus.kdone), 128'd0);
        wait_kdone(k0, "abort_kdone_latency");
        tick(5);
        chk("abort_no_done", 128'(n_done - snap), 128'd0);
        chk("abort_text_out_held", bus.text_out, C1_PT);
        start_ld(B_CT, 1'b1, B_PT);
        drain("abort_newkey_drain");

        // Reset at E4 discards everything.
        snap = n_done;
        start_ld(B_CT, 1'b0, '0);
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("midrst_done", 128'(bus.done), 128'd0);
        chk("midrst_kdone", 128'(bus.kdone), 128'd0);
        chk("midrst_text_out", bus.text_out, 128'd0);
        chk("midrst_rk10", dut.u_key_sched.r_rk10, 128'd0);
        rst = 1'b1;
        start_ld(B_CT, 1'b0, '0);
        tick(15);
        chk("midrst_ld_ignored", 128'(n_done - snap), 128'd0);
        load_key(B_KEY, k0);
        wait_kdone(k0, "midrst_kdone_latency");
        start_ld(B_CT, 1'b1, B_PT);
        drain("midrst_reload_drain");

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
